rd_cmd_gen_v1_0: RTL and testbench
==================================

// Module: rd_cmd_gen_v1_0
// PURPOSE
//  Read-command stage directly upstream of the DFI read-data checker in the DDR3 example design.
//  Per test request it does four things:
//  - captures one address/length pair;
//  - pulses cmd_rd_start to the checker;
//  - issues random_len+1 single-burst (BL8) read commands to the controller over a valid/ready port;
//  - waits for the checker's read_finished, then reports done.
//  With repeat enabled, the same burst set is replayed read_repeat_num+1 times.
// PARAMETERS
//  CTRL_ADDR_WIDTH     27  controller address width
//  MEM_COL_ADDR_WIDTH  10  column field width; the column occupies the LSBs of the address
//  TIMEOUT_CYCLES      4096  watchdog limit in clk cycles (used only with RD_TIMEOUT_EN)
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous active-low reset
//  rd_req          in   1   one-cycle request from the test sequencer; ignored unless the FSM is in S_IDLE
//  random_rw_addr  in   CTRL_ADDR_WIDTH  start address, sampled on an accepted rd_req
//  random_len      in   4   number of bursts minus 1, sampled on an accepted rd_req
//  read_repeat_en  in   1   enable replay, sampled on an accepted rd_req
//  read_repeat_num in   4   number of extra replays, sampled on an accepted rd_req
//  cmd_rd_start    out  1   one-cycle pulse to the checker at the start of each pass
//  read_finished   in   1   checker: all requested beats returned
//  rd_cmd_valid    out  1   read command valid toward the controller
//  rd_cmd_ready    in   1   controller accepts the command when valid & ready
//  rd_cmd_addr     out  CTRL_ADDR_WIDTH  burst address
//  rd_busy         out  1   high whenever the FSM is not in S_IDLE
//  rd_done         out  1   one-cycle pulse when the last pass completes
//  rd_timeout      out  1   sticky watchdog flag; constant 0 without RD_TIMEOUT_EN
// BEHAVIOUR
//  Reset values: every output is 0, and FSM = S_IDLE.
//  FSM states S_IDLE, S_START, S_ISSUE, S_WAIT, S_DONE.
//  S_IDLE:
//  - rd_req captures addr, len, repeat_en and repeat_num;
//  - clears pass_cnt;
//  - goes to S_START.
//  S_START (one cycle):
//  - cmd_rd_start=1;
//  - loads burst_cnt=len and cur_addr=captured addr;
//  - goes to S_ISSUE.
//  S_ISSUE:
//  - rd_cmd_valid=1 and rd_cmd_addr=cur_addr;
//  - valid and addr stay stable until a handshake;
//  - on each handshake, cur_addr column += 8, wrapping modulo 2^MEM_COL_ADDR_WIDTH; upper bits unchanged;
//  - after the handshake with burst_cnt==0, goes to S_WAIT; otherwise burst_cnt decrements.
//  - Back-to-back commands are allowed, with one command per cycle while ready stays high.
//  S_WAIT:
//  - waits for read_finished==1, but only sampled from the 2nd S_WAIT cycle onward; this masks the stale-high level.
//  - If repeat_en and pass_cnt!=repeat_num: pass_cnt++ and go to S_START.
//  - Otherwise go to S_DONE.
//  S_DONE: rd_done=1 for one cycle, then go to S_IDLE.
//  Timing and edge cases:
//  - Latency from rd_req to the first rd_cmd_valid is 2 cycles.
//  - cmd_rd_start always precedes the first valid of its pass by exactly 1 cycle.
//  - random_len=0 gives exactly 1 command per pass.
//  - repeat_num=0 with repeat_en=1 gives 1 pass.
//  - Asserting rst_n mid-operation drops rd_cmd_valid immediately, and no partial state survives.
// CONFIGURATION
//  RD_TIMEOUT_EN defined:
//  - a 16-bit counter runs while the FSM is in S_ISSUE or S_WAIT and clears on every state change;
//  - when it reaches TIMEOUT_CYCLES, rd_timeout is set (sticky until reset) and the FSM is forced to S_DONE, so rd_done pulses;
//  - rd_cmd_valid deasserts.
//  RD_TIMEOUT_EN undefined: no counter is built, rd_timeout is tied to 0, and the FSM waits indefinitely.
// STRUCTURE
//  Shared package ddr_test_pkg:
//  - FSM state localparams S_IDLE..S_DONE (3 bits);
//  - BURST_COL_STEP=8.
//  Single flat module; no sub-modules. The column-wrap adder is inline.
// TESTING
//  1. addr=0x0000100, len=3, no repeat, ready=1 -> cmd_rd_start once; addrs 0x100, 0x108, 0x110, 0x118; read_finished -> rd_done.
//  2. col=0x3F8, len=1 -> addrs 0x..3F8 then 0x..000; upper address bits unchanged.
//  3. ready toggling 1010 with len=2 -> 3 handshakes total; valid/addr held stable while ready=0.
//  4. repeat_en=1, repeat_num=2, len=0 -> 3 cmd_rd_start pulses and 3 identical addrs; 1 rd_done.
//  5. RD_TIMEOUT_EN, TIMEOUT_CYCLES=16, read_finished held 0 -> rd_timeout=1 and rd_done after 16 cycles in S_WAIT.
//  6. rst_n low during S_ISSUE -> all outputs 0 immediately; rd_req after release -> clean new sequence.

Source files
------------

// File: rtl/ddr_test_pkg.sv
// rtl/ddr_test_pkg.sv - shared DDR3 example-design constants: read-command FSM encoding and burst step.
package ddr_test_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One BL8 burst advances the column by eight beats.
  localparam int BURST_COL_STEP = 8;

endpackage

// File: rtl/rd_cmd_gen_v1_0.sv
// rtl/rd_cmd_gen_v1_0.sv - read-command generator feeding the DFI read-data checker.
// Optional watchdog built when RD_TIMEOUT_EN is defined.
module rd_cmd_gen_v1_0
  import ddr_test_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH    = 27,
  parameter int MEM_COL_ADDR_WIDTH = 10,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_req,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_len,
  input  logic                       read_repeat_en,
  input  logic [3:0]                 read_repeat_num,
  output logic                       cmd_rd_start,
  input  logic                       read_finished,
  output logic                       rd_cmd_valid,
  input  logic                       rd_cmd_ready,
  output logic [CTRL_ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic                       rd_busy,
  output logic                       rd_done,
  output logic                       rd_timeout
);

  logic [2:0]                    state_q, state_d;
  logic [CTRL_ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [3:0]                    len_q, len_d;
  logic                          rep_en_q, rep_en_d;
  logic [3:0]                    rep_num_q, rep_num_d;
  logic [3:0]                    pass_cnt_q, pass_cnt_d;
  logic [3:0]                    burst_cnt_q, burst_cnt_d;
  logic [CTRL_ADDR_WIDTH-1:0]    cur_addr_q, cur_addr_d;
  logic                          wait_arm_q, wait_arm_d;

  logic [MEM_COL_ADDR_WIDTH-1:0] col_next;
  logic [CTRL_ADDR_WIDTH-1:0]    addr_next;
  logic                          hs;

  // Column wraps inside its field; row/bank bits above it never change.
  assign col_next  = cur_addr_q[MEM_COL_ADDR_WIDTH-1:0] + MEM_COL_ADDR_WIDTH'(BURST_COL_STEP);
  assign addr_next = {cur_addr_q[CTRL_ADDR_WIDTH-1:MEM_COL_ADDR_WIDTH], col_next};
  assign hs        = (state_q == S_ISSUE) && rd_cmd_ready;

`ifdef RD_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
  logic        tmo_active;
  assign tmo_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    rep_en_d    = rep_en_q;
    rep_num_d   = rep_num_q;
    pass_cnt_d  = pass_cnt_q;
    burst_cnt_d = burst_cnt_q;
    cur_addr_d  = cur_addr_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          addr_d     = random_rw_addr;
          len_d      = random_len;
          rep_en_d   = read_repeat_en;
          rep_num_d  = read_repeat_num;
          pass_cnt_d = 4'd0;
          state_d    = S_START;
        end
      end
      S_START: begin
        burst_cnt_d = len_q;
        cur_addr_d  = addr_q;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (hs) begin
          cur_addr_d = addr_next;
          if (burst_cnt_q == 4'd0) begin
            state_d = S_WAIT;
          end else begin
            burst_cnt_d = burst_cnt_q - 4'd1;
          end
        end
      end
      S_WAIT: begin
        // The first WAIT cycle may still see read_finished from the prior pass.
        if (wait_arm_q && read_finished) begin
          if (rep_en_q && (pass_cnt_q != rep_num_q)) begin
            pass_cnt_d = pass_cnt_q + 4'd1;
            state_d    = S_START;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef RD_TIMEOUT_EN
    timeout_d = timeout_q;
    if (tmo_active && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1))) begin
      state_d   = S_DONE;
      timeout_d = 1'b1;
    end
    if (state_d != state_q) begin
      tmo_cnt_d = 16'd0;
    end else if (tmo_active) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_d = 16'd0;
    end
`endif

    wait_arm_d = (state_q == S_WAIT) && (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      rep_en_q    <= 1'b0;
      rep_num_q   <= '0;
      pass_cnt_q  <= '0;
      burst_cnt_q <= '0;
      cur_addr_q  <= '0;
      wait_arm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      rep_en_q    <= rep_en_d;
      rep_num_q   <= rep_num_d;
      pass_cnt_q  <= pass_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      cur_addr_q  <= cur_addr_d;
      wait_arm_q  <= wait_arm_d;
    end
  end

`ifdef RD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign rd_timeout = timeout_q;
`else
  assign rd_timeout = 1'b0;
`endif

  assign cmd_rd_start = (state_q == S_START);
  assign rd_cmd_valid = (state_q == S_ISSUE);
  assign rd_cmd_addr  = cur_addr_q;
  assign rd_busy      = (state_q != S_IDLE);
  assign rd_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_rd_cmd_gen_v1_0.sv
// tb/tb_rd_cmd_gen_v1_0.sv - directed vector bench for rd_cmd_gen_v1_0.
module tb_rd_cmd_gen_v1_0;

  typedef struct {
    logic [26:0] addr;
    logic [3:0]  len;
    logic        rep_en;
    logic [3:0]  rep_num;
    logic [3:0]  rdy_pat;   // ready per cycle, MSB first, repeating every 4 cycles
    int          rf_on;     // cycle from which read_finished is held high
    int          exp_cmds;
    int          exp_starts;
    int          exp_done_c;
    logic        exp_to;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [26:0] random_rw_addr = '0;
  logic [3:0]  random_len = '0;
  logic        read_repeat_en = 1'b0;
  logic [3:0]  read_repeat_num = '0;
  logic        cmd_rd_start;
  logic        read_finished = 1'b0;
  logic        rd_cmd_valid;
  logic        rd_cmd_ready = 1'b0;
  logic [26:0] rd_cmd_addr;
  logic        rd_busy;
  logic        rd_done;
  logic        rd_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rd_cmd_gen_v1_0 #(
    .CTRL_ADDR_WIDTH   (27),
    .MEM_COL_ADDR_WIDTH(10),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req         (rd_req),
    .random_rw_addr (random_rw_addr),
    .random_len     (random_len),
    .read_repeat_en (read_repeat_en),
    .read_repeat_num(read_repeat_num),
    .cmd_rd_start   (cmd_rd_start),
    .read_finished  (read_finished),
    .rd_cmd_valid   (rd_cmd_valid),
    .rd_cmd_ready   (rd_cmd_ready),
    .rd_cmd_addr    (rd_cmd_addr),
    .rd_busy        (rd_busy),
    .rd_done        (rd_done),
    .rd_timeout     (rd_timeout)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, ".start"}, longint'(cmd_rd_start), 0);
    chk({name, ".valid"}, longint'(rd_cmd_valid), 0);
    chk({name, ".addr"},  longint'(rd_cmd_addr), 0);
    chk({name, ".busy"},  longint'(rd_busy), 0);
    chk({name, ".done"},  longint'(rd_done), 0);
    chk({name, ".tmo"},   longint'(rd_timeout), 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int          starts = 0, dones = 0, done_c = -1, first_v = -1;
    int          stab_err = 0, busy_err = 0;
    logic        pend = 1'b0;
    logic [26:0] pend_addr = '0;
    logic [26:0] got[$];
    logic [9:0]  col;
    logic [26:0] exp_a;
    @(negedge clk);
    random_rw_addr  = v.addr;
    random_len      = v.len;
    read_repeat_en  = v.rep_en;
    read_repeat_num = v.rep_num;
    rd_req          = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) rd_req = 1'b0;
      rd_cmd_ready  = v.rdy_pat[3 - (c % 4)];
      read_finished = (c >= v.rf_on);
      #1;
      if (pend && !(rd_cmd_valid && rd_cmd_addr == pend_addr)) stab_err++;
      pend      = rd_cmd_valid && !rd_cmd_ready;
      pend_addr = rd_cmd_addr;
      if (cmd_rd_start) starts++;
      if (rd_cmd_valid && first_v < 0) first_v = c;
      if (rd_cmd_valid && rd_cmd_ready) got.push_back(rd_cmd_addr);
      if (c >= 1 && !rd_busy) busy_err++;
      if (rd_done) begin
        dones++;
        done_c = c;
        chk({name, ".timeout_flag"}, longint'(rd_timeout), longint'(v.exp_to));
        break;
      end
    end
    chk({name, ".done_seen"}, dones, 1);
    chk({name, ".done_cycle"}, done_c, v.exp_done_c);
    chk({name, ".first_valid_cycle"}, first_v, 2);
    chk({name, ".starts"}, starts, v.exp_starts);
    chk({name, ".cmds"}, got.size(), v.exp_cmds);
    chk({name, ".stable_while_stalled"}, stab_err, 0);
    chk({name, ".busy_while_active"}, busy_err, 0);
    for (int k = 0; k < got.size(); k++) begin
      col   = v.addr[9:0] + 10'(8 * (k % (int'(v.len) + 1)));
      exp_a = {v.addr[26:10], col};
      chk($sformatf("%s.addr%0d", name, k), longint'(got[k]), longint'(exp_a));
    end
    rd_cmd_ready  = 1'b0;
    read_finished = 1'b0;
    @(negedge clk);
    #1;
    chk({name, ".idle_after_done"}, longint'(rd_busy), 0);
  endtask

  vec_t vecs[7];
  vec_t tv;

  initial begin
    //         addr          len   ren   rnum  rdy     rf  cmds st done to
    vecs[0] = '{27'h0000100, 4'd3, 1'b0, 4'd0, 4'hF,   0,  4,   1, 8,   1'b0};
    vecs[1] = '{27'h5A5A3F8, 4'd1, 1'b0, 4'd0, 4'hF,   0,  2,   1, 6,   1'b0};
    vecs[2] = '{27'h0000200, 4'd2, 1'b0, 4'd0, 4'hA,   0,  3,   1, 9,   1'b0};
    vecs[3] = '{27'h0ABCDE8, 4'd0, 1'b1, 4'd2, 4'hF,   0,  3,   3, 13,  1'b0};
    vecs[4] = '{27'h1234560, 4'd0, 1'b0, 4'd5, 4'hF,   0,  1,   1, 5,   1'b0};
    vecs[5] = '{27'h0000040, 4'd0, 1'b1, 4'd0, 4'hF,   0,  1,   1, 5,   1'b0};
    vecs[6] = '{27'h7FFFFF8, 4'd0, 1'b0, 4'd0, 4'hF,   7,  1,   1, 8,   1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef RD_TIMEOUT_EN
    tv = '{27'h0000300, 4'd0, 1'b0, 4'd0, 4'hF, 1000, 1, 1, 19, 1'b1};
    run_vec(tv, "timeout");
`endif

    // Reset while stalled in the issue state.
    @(negedge clk);
    random_rw_addr  = 27'h0000480;
    random_len      = 4'd7;
    read_repeat_en  = 1'b0;
    read_repeat_num = 4'd0;
    rd_cmd_ready    = 1'b0;
    rd_req          = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_reset.valid", longint'(rd_cmd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
